// File: rtl/peak_find_multiwin.sv
// Multi-window hysteresis peak detector over an external sample RAM.
// Scans NWIN address windows and streams every qualified peak record.
module peak_find_multiwin #(
   parameter int DW     = 8,
   parameter int AW     = 12,
   parameter int NWIN   = 3,
   parameter int WIW    = 2,
   parameter int RD_LAT = 3,
   parameter int DELTA  = 5,
   parameter int SPREAD = 60,
   parameter int MINTOL = 4,
   parameter int MAXPK  = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [NWIN*AW-1:0] cfg_start,
   input  logic [NWIN*AW-1:0] cfg_len,
   output logic               mem_rd,
   output logic [AW-1:0]      mem_addr,
   input  logic [DW-1:0]      mem_data,
   output logic               pk_valid,
   input  logic               pk_ready,
   output logic [AW-1:0]      pk_x,
   output logic [DW-1:0]      pk_y,
   output logic [WIW-1:0]     pk_win,
   output logic               busy,
   output logic               done,
   output logic [7:0]         pk_total,
   output logic               ovf
);

   localparam int CW  = $clog2(MAXPK + 1);
   localparam int LW  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam int DW1 = DW + 1;
   localparam logic [DW:0] DLT = DW1'(DELTA);

   typedef enum logic [2:0] {
      S_IDLE, S_WINIT, S_ISSUE, S_WAIT,
      S_EVAL, S_EMIT, S_NEXTW, S_DONE
   } state_t;

   state_t          state;
   logic [AW-1:0]   base_q [NWIN];
   logic [AW-1:0]   len_q  [NWIN];
   logic [WIW-1:0]  w;
   logic [AW-1:0]   off;
   logic [AW-1:0]   mx_off;
   logic [AW-1:0]   rise_off;
   logic [DW-1:0]   mx;
   logic [DW-1:0]   mn;
   logic [DW-1:0]   valley;
   logic [DW-1:0]   s;
   logic            look;
   logic [CW-1:0]   cnt;
   logic [LW-1:0]   wc;

   logic [AW-1:0]   cur_base;
   logic [AW-1:0]   cur_len;
   logic [AW-1:0]   off_inc;
   logic [DW-1:0]   t_mx;
   logic [DW-1:0]   t_mn;
   logic [AW-1:0]   t_mx_off;
   logic [DW-1:0]   n_mx;
   logic [DW-1:0]   n_mn;
   logic [DW-1:0]   n_valley;
   logic [AW-1:0]   n_mx_off;
   logic [AW-1:0]   n_rise;
   logic            n_look;
   logic            qual;

   assign cur_base = base_q[w];
   assign cur_len  = len_q[w];
   assign off_inc  = off + AW'(1);

   // Evaluate one sample: running extrema, then rise/fall hysteresis decision.
   always_comb begin
      t_mx     = mx;
      t_mx_off = mx_off;
      t_mn     = mn;
      if (s > mx) begin
         t_mx     = s;
         t_mx_off = off;
      end
      if (s < mn) t_mn = s;
      n_mx     = t_mx;
      n_mx_off = t_mx_off;
      n_mn     = t_mn;
      n_look   = look;
      n_rise   = rise_off;
      n_valley = valley;
      qual     = 1'b0;
      if (!look && ({1'b0, s} > {1'b0, t_mn} + DLT)) begin
         n_look   = 1'b1;
         n_rise   = off;
         n_valley = t_mn;
         n_mx     = s;
         n_mx_off = off;
      end else if (look && ({1'b0, s} + DLT < {1'b0, t_mx})) begin
         qual   = ((off - t_mx_off) < AW'(SPREAD)) &&
                  ((off - rise_off) > AW'(MINTOL));
         n_mx   = s;
         n_mn   = s;
         n_look = 1'b0;
      end
   end

   // Scan controller with registered read strobe, peak stream and status.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         for (int i = 0; i < NWIN; i++) begin
            base_q[i] <= '0;
            len_q[i]  <= '0;
         end
         w        <= '0;
         off      <= '0;
         mx_off   <= '0;
         rise_off <= '0;
         mx       <= '0;
         mn       <= '1;
         valley   <= '0;
         s        <= '0;
         look     <= 1'b0;
         cnt      <= '0;
         wc       <= '0;
         mem_rd   <= 1'b0;
         mem_addr <= '0;
         pk_valid <= 1'b0;
         pk_x     <= '0;
         pk_y     <= '0;
         pk_win   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pk_total <= '0;
         ovf      <= 1'b0;
      end else begin
         mem_rd <= 1'b0;
         done   <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  for (int i = 0; i < NWIN; i++) begin
                     base_q[i] <= cfg_start[i*AW +: AW];
                     len_q[i]  <= cfg_len[i*AW +: AW];
                  end
                  w        <= '0;
                  ovf      <= 1'b0;
                  pk_total <= '0;
                  busy     <= 1'b1;
                  state    <= S_WINIT;
               end
            end
            S_WINIT: begin
               off  <= '0;
               mx   <= '0;
               mn   <= '1;
               look <= 1'b0;
               cnt  <= '0;
               if (cur_len == '0) begin
                  state <= S_NEXTW;
               end else begin
                  mem_rd   <= 1'b1;
                  mem_addr <= cur_base;
                  state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               wc    <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (wc == LW'(RD_LAT - 1)) begin
                  s     <= mem_data;
                  state <= S_EVAL;
               end else begin
                  wc <= wc + LW'(1);
               end
            end
            S_EVAL: begin
               mx       <= n_mx;
               mx_off   <= n_mx_off;
               mn       <= n_mn;
               look     <= n_look;
               rise_off <= n_rise;
               valley   <= n_valley;
               off      <= off_inc;
               if (qual && (cnt < CW'(MAXPK))) begin
                  pk_x     <= cur_base + t_mx_off;
                  pk_y     <= t_mx - valley;
                  pk_win   <= w;
                  pk_valid <= 1'b1;
                  cnt      <= cnt + CW'(1);
                  if (pk_total != 8'hFF) pk_total <= pk_total + 8'd1;
                  state    <= S_EMIT;
               end else begin
                  if (qual) ovf <= 1'b1;
                  if (off_inc == cur_len) begin
                     state <= S_NEXTW;
                  end else begin
                     mem_rd   <= 1'b1;
                     mem_addr <= cur_base + off_inc;
                     state    <= S_ISSUE;
                  end
               end
            end
            S_EMIT: begin
               if (pk_ready) begin
                  pk_valid <= 1'b0;
                  if (off == cur_len) begin
                     state <= S_NEXTW;
                  end else begin
                     mem_rd   <= 1'b1;
                     mem_addr <= cur_base + off;
                     state    <= S_ISSUE;
                  end
               end
            end
            S_NEXTW: begin
               if (w == WIW'(NWIN - 1)) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  w     <= w + WIW'(1);
                  state <= S_WINIT;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_peak_find_multiwin.sv
// Directed and random scans of peak_find_multiwin against a sample-list model.
// Models the RAM with a fixed-latency read pipeline.
module tb_peak_find_multiwin;

   localparam int DW     = 8;
   localparam int AW     = 12;
   localparam int NWIN   = 3;
   localparam int WIW    = 2;
   localparam int RD_LAT = 3;
   localparam int DELTA  = 5;
   localparam int SPREAD = 60;
   localparam int MINTOL = 4;
   localparam int MAXPK  = 2;

   logic               clk;
   logic               rst;
   logic               start;
   logic [NWIN*AW-1:0] cfg_start;
   logic [NWIN*AW-1:0] cfg_len;
   logic               mem_rd;
   logic [AW-1:0]      mem_addr;
   logic [DW-1:0]      mem_data;
   logic               pk_valid;
   logic               pk_ready;
   logic [AW-1:0]      pk_x;
   logic [DW-1:0]      pk_y;
   logic [WIW-1:0]     pk_win;
   logic               busy;
   logic               done;
   logic [7:0]         pk_total;
   logic               ovf;

   peak_find_multiwin #(
      .DW(DW), .AW(AW), .NWIN(NWIN), .WIW(WIW), .RD_LAT(RD_LAT),
      .DELTA(DELTA), .SPREAD(SPREAD), .MINTOL(MINTOL), .MAXPK(MAXPK)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .cfg_start(cfg_start), .cfg_len(cfg_len),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
      .pk_valid(pk_valid), .pk_ready(pk_ready),
      .pk_x(pk_x), .pk_y(pk_y), .pk_win(pk_win),
      .busy(busy), .done(done), .pk_total(pk_total), .ovf(ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int ntests = 0;
   int nfail  = 0;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] outs();
      return {17'd0, mem_rd, mem_addr, pk_valid, pk_x, pk_y, pk_win,
              busy, done, pk_total, ovf};
   endfunction

   // RAM model: data appears RD_LAT cycles after the read strobe cycle.
   logic [7:0]    mem [4096];
   logic          dv  [RD_LAT];
   logic [AW-1:0] da  [RD_LAT];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) dv[i] <= 1'b0;
      end else begin
         dv[0] <= mem_rd;
         da[0] <= mem_addr;
         for (int i = 1; i < RD_LAT; i++) begin
            dv[i] <= dv[i-1];
            da[i] <= da[i-1];
         end
      end
   end
   assign mem_data = dv[RD_LAT-1] ? mem[da[RD_LAT-1]] : 8'hEE;

   // Consumer: 0 = always ready, 1 = random, 2 = held off.
   int rdy_mode = 0;
   initial begin
      pk_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       pk_ready = 1'b1;
            1:       pk_ready = 1'($urandom_range(1));
            default: pk_ready = 1'b0;
         endcase
      end
   end

   // Reference model over the sample list of each window.
   int          cs [NWIN];
   int          cl [NWIN];
   logic [31:0] exp_addr[$];
   logic [31:0] exp_rec[$];
   int          exp_total;
   logic        exp_ovf;

   function automatic void model();
      int mx, mn, mxo, rise, valley, cnt, a, s;
      bit look;
      exp_addr.delete();
      exp_rec.delete();
      exp_total = 0;
      exp_ovf = 1'b0;
      for (int w = 0; w < NWIN; w++) begin
         mx = 0; mn = 255; mxo = 0; rise = 0; valley = 0; cnt = 0;
         look = 1'b0;
         for (int off = 0; off < cl[w]; off++) begin
            a = (cs[w] + off) % 4096;
            s = int'(mem[a]);
            exp_addr.push_back(32'(a));
            if (s > mx) begin mx = s; mxo = off; end
            if (s < mn) mn = s;
            if (!look && s > mn + DELTA) begin
               look = 1'b1; rise = off; valley = mn; mx = s; mxo = off;
            end else if (look && s + DELTA < mx) begin
               if (off - mxo < SPREAD && off - rise > MINTOL) begin
                  if (cnt < MAXPK) begin
                     exp_rec.push_back(32'((w << 20) |
                        (((cs[w] + mxo) % 4096) << 8) | (mx - valley)));
                     cnt++;
                     if (exp_total < 255) exp_total++;
                  end else begin
                     exp_ovf = 1'b1;
                  end
               end
               mx = s; mn = s; look = 1'b0;
            end
         end
      end
   endfunction

   // Monitor: reads, handshakes, done pulse, stall behaviour.
   logic [31:0] rd_log[$];
   logic [31:0] rec_log[$];
   int          done_cnt = 0;
   logic        busy_at_done;
   logic [7:0]  tot_at_done;
   logic        ovf_at_done;
   logic        pv_prev = 1'b0;
   logic        hs_prev = 1'b0;
   logic [31:0] rec_prev;
   always @(negedge clk) begin : mon
      logic [31:0] cur;
      if (rst) begin
         pv_prev = 1'b0;
         hs_prev = 1'b0;
      end else begin
         cur = {10'd0, pk_win, pk_x, pk_y};
         if (mem_rd) rd_log.push_back(32'(mem_addr));
         if (pk_valid && pv_prev && !hs_prev) check("rec_stable", 64'(cur), 64'(rec_prev));
         if (pk_valid) check("no_rd_while_valid", 64'(mem_rd), 64'd0);
         if (pk_valid && pk_ready) rec_log.push_back(cur);
         if (done) begin
            done_cnt++;
            busy_at_done = busy;
            tot_at_done = pk_total;
            ovf_at_done = ovf;
         end
         pv_prev = pk_valid;
         hs_prev = pk_valid && pk_ready;
         rec_prev = cur;
      end
   end

   task automatic launch();
      model();
      rd_log.delete();
      rec_log.delete();
      done_cnt = 0;
      for (int w = 0; w < NWIN; w++) begin
         cfg_start[w*AW +: AW] = AW'(cs[w]);
         cfg_len[w*AW +: AW]   = AW'(cl[w]);
      end
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check("busy_after_start", 64'(busy), 64'd1);
   endtask

   task automatic finish_scan(input string tag);
      int n;
      n = 0;
      while (done_cnt == 0 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
      repeat (3) @(negedge clk);
      check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
      check({tag, "_busy_at_done"}, 64'(busy_at_done), 64'd0);
      check({tag, "_idle_after"}, 64'({busy, done}), 64'd0);
      check({tag, "_total"}, 64'(tot_at_done), 64'(exp_total));
      check({tag, "_total_held"}, 64'(pk_total), 64'(exp_total));
      check({tag, "_ovf"}, 64'(ovf_at_done), 64'(exp_ovf));
      check({tag, "_nreads"}, 64'(rd_log.size()), 64'(exp_addr.size()));
      for (int i = 0; i < rd_log.size() && i < exp_addr.size(); i++)
         check({tag, "_addr"}, 64'(rd_log[i]), 64'(exp_addr[i]));
      check({tag, "_nrec"}, 64'(rec_log.size()), 64'(exp_rec.size()));
      for (int i = 0; i < rec_log.size() && i < exp_rec.size(); i++)
         check({tag, "_rec"}, 64'(rec_log[i]), 64'(exp_rec[i]));
   endtask

   task automatic fill_t1(input int base);
      for (int off = 0; off < 30; off++)
         mem[(base + off) % 4096] = (off < 5) ? 8'd10 :
            (off < 12) ? 8'(10 + 5 * (off - 5)) : 8'd30;
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      while (!pk_valid && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check(tag, 64'(pk_valid), 64'd1);
   endtask

   initial begin
      int v;
      logic [7:0] blk [16];
      rst = 1'b1;
      start = 1'b0;
      cfg_start = '0;
      cfg_len = '0;
      for (int a = 0; a < 4096; a++) mem[a] = 8'd0;
      repeat (3) @(negedge clk);
      check("reset_outs", outs(), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_outs", outs(), 64'd0);

      // Single-peak reference vector.
      fill_t1(50);
      cs = '{50, 0, 0};
      cl = '{30, 0, 0};
      launch();
      finish_scan("t1");
      check("t1_count", 64'(rec_log.size()), 64'd1);
      if (rec_log.size() > 0)
         check("t1_rec", 64'(rec_log[0]), 64'({10'd0, 2'd0, 12'd61, 8'd30}));
      check("t1_total", 64'(tot_at_done), 64'd1);

      // Flat data over three windows.
      for (int a = 0; a < 4096; a++) mem[a] = 8'd77;
      cs = '{50, 100, 180};
      cl = '{30, 80, 240};
      launch();
      finish_scan("flat");
      check("flat_norec", 64'(rec_log.size()), 64'd0);
      check("flat_reads", 64'(rd_log.size()), 64'd350);

      // Empty middle window.
      for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom_range(255));
      cs = '{50, 100, 180};
      cl = '{30, 0, 40};
      launch();
      finish_scan("skip");
      check("skip_reads", 64'(rd_log.size()), 64'd70);

      // Address wrap.
      cs = '{4090, 0, 0};
      cl = '{10, 0, 0};
      launch();
      finish_scan("wrap");
      for (int i = 0; i < 10 && i < rd_log.size(); i++)
         check("wrap_addr", 64'(rd_log[i]), 64'((4090 + i) % 4096));

      // Backpressure.
      fill_t1(50);
      cs = '{50, 0, 0};
      cl = '{30, 0, 0};
      rdy_mode = 2;
      launch();
      wait_valid("bp_valid_seen");
      repeat (20) begin
         @(negedge clk);
         check("bp_hold", 64'(pk_valid), 64'd1);
         check("bp_nord", 64'(mem_rd), 64'd0);
      end
      rdy_mode = 0;
      finish_scan("bp");
      check("bp_single", 64'(rec_log.size()), 64'd1);

      // Three qualifying peaks, two allowed.
      blk = '{8'd10, 8'd10, 8'd10, 8'd20, 8'd25, 8'd30, 8'd35, 8'd40,
              8'd45, 8'd50, 8'd40, 8'd20, 8'd10, 8'd10, 8'd10, 8'd10};
      for (int off = 0; off < 48; off++) mem[300 + off] = blk[off % 16];
      cs = '{300, 0, 0};
      cl = '{48, 0, 0};
      launch();
      finish_scan("maxpk");
      check("maxpk_recs", 64'(rec_log.size()), 64'd2);
      check("maxpk_ovf", 64'(ovf_at_done), 64'd1);

      // Spread too wide, then a later valid peak.
      for (int off = 0; off < 100; off++)
         mem[500 + off] = (off < 3) ? 8'd10 :
            (off < 10) ? 8'(20 + 10 * (off - 3)) :
            (off < 80) ? 8'd80 :
            (off < 86) ? 8'd40 :
            (off < 96) ? 8'(50 + 10 * (off - 86)) : 8'd60;
      cs = '{500, 0, 0};
      cl = '{100, 0, 0};
      launch();
      finish_scan("spread");
      check("spread_recs", 64'(rec_log.size()), 64'd1);
      if (rec_log.size() > 0)
         check("spread_rec", 64'(rec_log[0]), 64'({10'd0, 2'd0, 12'd595, 8'd100}));

      // Reset while a record is pending, then rescan.
      fill_t1(50);
      cs = '{50, 0, 0};
      cl = '{30, 0, 0};
      rdy_mode = 2;
      launch();
      wait_valid("rst_valid_seen");
      @(negedge clk);
      rst = 1'b1;
      #1 check("rst_async", outs(), 64'd0);
      @(posedge clk);
      #1 check("rst_edge", outs(), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      rdy_mode = 0;
      launch();
      finish_scan("rescan");

      // Random walks with random windows and random backpressure.
      for (int it = 0; it < 6; it++) begin
         v = 128;
         for (int a = 0; a < 4096; a++) begin
            v = v + int'($urandom_range(24)) - 12;
            if (v < 0) v = 0;
            if (v > 255) v = 255;
            mem[a] = 8'(v);
         end
         for (int w = 0; w < NWIN; w++) begin
            cs[w] = int'($urandom_range(4095));
            cl[w] = int'($urandom_range(90));
         end
         if (it == 2) cl[0] = 40;
         rdy_mode = 1;
         launch();
         if (it == 2) begin
            repeat (10) @(posedge clk);
            #1;
            cfg_start = '1;
            cfg_len = '1;
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
         end
         finish_scan("rand");
      end
      rdy_mode = 0;

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
